fp_serializer: RTL
==================

FP_SERIALIZER -- requirements
Module: fp_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4, number of buffered words; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  high when the upstream converter presents a valid floating-point word.
REQ-006 in_ready  output  1  high when a word can be accepted this cycle.
REQ-007 s_in  input  1  sign bit from the converter.
REQ-008 e_in  input  3  exponent from the converter.
REQ-009 f_in  input  4  significand from the converter.
REQ-010 tx  output  1  serial line; idles high.
REQ-011 busy  output  1  high while a frame is on the line.
REQ-012 frame_done  output  1  one-cycle pulse when a frame's stop bit completes.
REQ-013 count  output  clog2(FIFO_DEPTH)+1  current FIFO fill level.

Function
REQ-014 Packing: data byte = {s_in, e_in, f_in}; bit7 = s_in, bit0 = f_in[0].
REQ-015 Push: write the byte on any edge where in_valid && in_ready; in_ready = (count != FIFO_DEPTH), from registered count only, no combinational path from pop.
REQ-016 Upstream holds s_in/e_in/f_in stable while in_valid && !in_ready; the block never drops or duplicates an accepted word.
REQ-017 FIFO: first-in first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-018 Push and pop on the same edge leave count unchanged; data order is preserved.
REQ-019 FSM states IDLE, START, DATA, STOP.
REQ-020 IDLE: tx=1, busy=0; if count != 0 on an edge, pop the head word into the shift register and enter START.
REQ-021 START: tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-022 DATA: shift out 8 bits LSB first, CLKS_PER_BIT cycles each; a 3-bit bit index counts 0..7, then enter STOP.
REQ-023 STOP: tx=1 for CLKS_PER_BIT cycles.
REQ-024 End of STOP: pulse frame_done for exactly one cycle on that edge.
REQ-025 End of STOP with count != 0: pop and enter START directly, with no idle cycle between frames.
REQ-026 End of STOP with count == 0: enter IDLE.
REQ-027 Frame length: exactly 10*CLKS_PER_BIT cycles.
REQ-028 Latency: word accepted at edge k into an empty FIFO in IDLE -> tx=0 from edge k+1.
REQ-029 busy = 1 in START, DATA and STOP.
REQ-030 tx, busy and frame_done are driven from registers (glitch-free).
REQ-031 A single bit-period counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.

Reset
REQ-032 While rst_n=0 at an edge: state=IDLE, tx=1, busy=0, frame_done=0, count=0, pointers=0, bit and period counters=0.
REQ-033 in_ready=0 while rst_n is low; in_ready=1 from the first edge after rst_n returns high.
REQ-034 Reset mid-frame aborts the frame: tx=1 after that edge, buffered words are discarded, no frame_done pulse.

Verification
REQ-035 Single word: s=0, e=011, f=1110 (0x3E), CLKS_PER_BIT=4 -> tx sequence 0, 0,1,1,1,1,1,0,0, 1, each held 4 cycles; frame_done 40 cycles after tx first falls; then tx=1, busy=0.
REQ-036 All-ones: s=1, e=111, f=1111 (0xFF) -> start bit 0 then nine 1-bit periods; frame_done at cycle 40.
REQ-037 Burst: 6 words pushed with in_valid held high -> in_ready drops when count=4; all 6 bytes appear in order; no idle cycle between frames; 6 frame_done pulses.
REQ-038 Full back-pressure: count=4 with in_valid=1 and changing data -> no write and count stays 4 until a pop; the word accepted after the pop is the one held at that edge.
REQ-039 Simultaneous events: count=1 with a push and a pop on the same edge -> count stays 1; the next frame carries the pushed word.
REQ-040 Reset during DATA bit 3 -> tx=1 and count=0 next cycle; a new word sent after reset is transmitted intact.

Source files
------------

// File: rtl/fp_serializer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_serializer_if : upstream word handshake and serial-line status bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface fp_serializer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int c_CW = $clog2(FIFO_DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic            s_in;
  logic [2:0]      e_in;
  logic [3:0]      f_in;
  logic            tx;
  logic            busy;
  logic            frame_done;
  logic [c_CW-1:0] count;

  modport master (
    output in_valid, s_in, e_in, f_in,
    input  in_ready, tx, busy, frame_done, count
  );

  modport slave (
    input  in_valid, s_in, e_in, f_in,
    output in_ready, tx, busy, frame_done, count
  );
endinterface
`default_nettype wire

// File: rtl/fp_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_serializer : buffers packed {s,e,f} bytes and sends them as 8N1 frames
// Rev 1.0
// ---------------------------------------------------------------------------
module fp_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_serializer_if.slave  bus
);

  localparam int                c_PW        = $clog2(FIFO_DEPTH);
  localparam int                c_CW        = c_PW + 1;
  localparam logic [c_CW-1:0]   c_FULL      = c_CW'(FIFO_DEPTH);
  localparam logic [7:0]        c_LAST_TICK = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [c_PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_CW-1:0] count_q, count_d;
  logic            alive_q;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            w_push;
  logic            w_pop;
  logic            w_tick_wrap;
  logic [7:0]      w_head;

  // alive_q keeps in_ready low through reset without a path from rst_n
  assign bus.in_ready   = alive_q && (count_q != c_FULL);
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.count      = count_q;

  assign w_push      = bus.in_valid && bus.in_ready;
  assign w_tick_wrap = (tick_q == c_LAST_TICK);
  assign w_head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {bus.s_in, bus.e_in, bus.f_in};
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    w_pop   = 1'b0;

    if (state_q != S_IDLE) begin
      tick_d = w_tick_wrap ? 8'd0 : tick_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (count_q != '0) begin
          w_pop   = 1'b1;
          shift_d = w_head;
          tick_d  = 8'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_tick_wrap) begin
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick_wrap) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            bit_d   = 3'd0;
            state_d = S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_tick_wrap) begin
          done_d = 1'b1;
          // back-to-back frames: reload straight into START, no idle gap
          if (count_q != '0) begin
            w_pop   = 1'b1;
            shift_d = w_head;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_CW'(1);
      2'b01:   count_d = count_q - c_CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      alive_q  <= 1'b0;
      shift_q  <= 8'd0;
      tick_q   <= 8'd0;
      bit_q    <= 3'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      alive_q <= 1'b1;
      shift_q <= shift_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + c_PW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_PW'(1);
      end
    end
  end

endmodule
`default_nettype wire
